// File: rtl/wall_size_div_pkg.sv
// Shared constants and state type for the wall-size divider and its serial divide core.
package wall_size_div_pkg;

    localparam int DIST_W    = 16;
    localparam int SIZE_W    = 11;
    localparam int NUM_W     = 20;
    localparam int SCALE_NUM = 524288;
    localparam int SIZE_MAX  = (1 << SIZE_W) - 1;
    localparam int CNT_W     = $clog2(NUM_W + 1);

    localparam int H_VIEW    = 640;
    localparam int HALF_SIZE = 320;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/wall_size_div_serial_udiv.sv
// Serial restoring unsigned divider: one quotient bit per cycle, MSB first, NUM_W cycles.
module serial_udiv
    import wall_size_div_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic [NUM_W-1:0]  dividend_i,
    input  logic [DIST_W-1:0] divisor_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [NUM_W-1:0]  quotient_o
);

    logic              busy_q, busy_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DIST_W:0]   rem_q, rem_d;
    logic [NUM_W-1:0]  quot_q, quot_d;
    logic [NUM_W-1:0]  dvd_q, dvd_d;
    logic [DIST_W-1:0] dsr_q, dsr_d;
    logic [DIST_W:0]   trial;
    logic              fits;

    // Remainder stays below the divisor, so its top bit is always zero before the shift.
    assign trial = {rem_q[DIST_W-1:0], dvd_q[NUM_W-1]};
    assign fits  = trial >= {1'b0, dsr_q};

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        rem_d  = rem_q;
        quot_d = quot_q;
        dvd_d  = dvd_q;
        dsr_d  = dsr_q;
        if (start_i) begin
            busy_d = 1'b1;
            cnt_d  = CNT_W'(NUM_W);
            rem_d  = '0;
            quot_d = '0;
            dvd_d  = dividend_i;
            dsr_d  = divisor_i;
        end else if (busy_q) begin
            rem_d  = fits ? (trial - {1'b0, dsr_q}) : trial;
            quot_d = {quot_q[NUM_W-2:0], fits};
            dvd_d  = {dvd_q[NUM_W-2:0], 1'b0};
            cnt_d  = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            quot_q <= '0;
            dvd_q  <= '0;
            dsr_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            rem_q  <= rem_d;
            quot_q <= quot_d;
            dvd_q  <= dvd_d;
            dsr_q  <= dsr_d;
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = busy_q && (cnt_q == CNT_W'(1));
    assign quotient_o = quot_q;

endmodule

// File: rtl/wall_size_div.sv
// Distance-to-wall-size converter: divides, saturates, buffers one result and commits it on row_start.
//   state   | meaning
//   IDLE    | waiting for a distance (ready only when nothing is pending)
//   DIV     | serial divide in progress
//   DONE    | saturate quotient into the pending buffer
module wall_size_div
    import wall_size_div_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DIST_W-1:0] in_dist,
    input  logic              in_side,
    input  logic              row_start,
    output logic [SIZE_W-1:0] size,
    output logic              side,
    output logic              stale
);

    localparam logic [NUM_W-1:0]  DIVIDEND = NUM_W'(SCALE_NUM);
    localparam logic [NUM_W-1:0]  SAT_Q    = NUM_W'(SIZE_MAX);
    localparam logic [SIZE_W-1:0] SAT_SIZE = SIZE_W'(SIZE_MAX);

    state_e            state_q, state_d;
    logic              lat_side_q, lat_side_d;
    logic              div0_q, div0_d;
    logic [SIZE_W-1:0] pend_size_q, pend_size_d;
    logic              pend_side_q, pend_side_d;
    logic              pend_valid_q, pend_valid_d;
    logic [SIZE_W-1:0] size_q, size_d;
    logic              side_q, side_d;
    logic              stale_q, stale_d;

    logic              accept;
    logic              div_start;
    logic              div_busy;
    logic              div_done;
    logic [NUM_W-1:0]  div_quot;

    assign in_ready  = (state_q == ST_IDLE) && !pend_valid_q && !div_busy;
    assign accept    = in_valid && in_ready;
    assign div_start = accept && (in_dist != '0);

    serial_udiv u_udiv (
        .clk        (clk),
        .reset      (reset),
        .start_i    (div_start),
        .dividend_i (DIVIDEND),
        .divisor_i  (in_dist),
        .busy_o     (div_busy),
        .done_o     (div_done),
        .quotient_o (div_quot)
    );

    always_comb begin
        state_d      = state_q;
        lat_side_d   = lat_side_q;
        div0_d       = div0_q;
        pend_size_d  = pend_size_q;
        pend_side_d  = pend_side_q;
        pend_valid_d = pend_valid_q;
        size_d       = size_q;
        side_d       = side_q;
        stale_d      = stale_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    lat_side_d = in_side;
                    div0_d     = (in_dist == '0);
                    state_d    = (in_dist == '0) ? ST_DONE : ST_DIV;
                end
            end
            ST_DIV: begin
                if (div_done) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (div0_q || (div_quot > SAT_Q)) begin
                    pend_size_d = SAT_SIZE;
                end else begin
                    pend_size_d = div_quot[SIZE_W-1:0];
                end
                pend_side_d  = lat_side_q;
                pend_valid_d = 1'b1;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // DONE only runs while nothing is pending, so this never collides with the set above.
        if (row_start) begin
            if (pend_valid_q) begin
                size_d       = pend_size_q;
                side_d       = pend_side_q;
                pend_valid_d = 1'b0;
                stale_d      = 1'b0;
            end else begin
                stale_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            lat_side_q   <= 1'b0;
            div0_q       <= 1'b0;
            pend_size_q  <= '0;
            pend_side_q  <= 1'b0;
            pend_valid_q <= 1'b0;
            size_q       <= '0;
            side_q       <= 1'b0;
            stale_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            lat_side_q   <= lat_side_d;
            div0_q       <= div0_d;
            pend_size_q  <= pend_size_d;
            pend_side_q  <= pend_side_d;
            pend_valid_q <= pend_valid_d;
            size_q       <= size_d;
            side_q       <= side_d;
            stale_q      <= stale_d;
        end
    end

    assign size  = size_q;
    assign side  = side_q;
    assign stale = stale_q;

endmodule

// File: tb/tb_wall_size_div.sv
// Directed bench for wall_size_div: exact latency, saturation, row commit and stale behaviour.
module tb_wall_size_div;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_dist;
    logic        in_side;
    logic        row_start;
    logic [10:0] size;
    logic        side;
    logic        stale;

    int n_checks = 0;
    int n_errors = 0;

    wall_size_div dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_dist   (in_dist),
        .in_side   (in_side),
        .row_start (row_start),
        .size      (size),
        .side      (side),
        .stale     (stale)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1 time unit after the accept edge.
    task automatic accept(input logic [15:0] d, input logic s);
        int w = 0;
        while (!in_ready && w < 50) begin
            step(1);
            w++;
        end
        check("ready_wait", 32'(in_ready), 32'd1);
        in_dist  = d;
        in_side  = s;
        in_valid = 1'b1;
        step(1);
        in_valid = 1'b0;
        check("busy_after_accept", 32'(in_ready), 32'd0);
    endtask

    task automatic commit();
        row_start = 1'b1;
        step(1);
        row_start = 1'b0;
    endtask

    // Accept on E0, result pending at E21, commit sampled at E22.
    task automatic run_div(input logic [15:0] d, input logic s, input logic [10:0] exp_size);
        accept(d, s);
        step(20);
        check("busy_until_commit", 32'(in_ready), 32'd0);
        step(1);
        commit();
        check($sformatf("size_d%0d", d), 32'(size), 32'(exp_size));
        check($sformatf("side_d%0d", d), 32'(side), 32'(s));
        check($sformatf("stale_d%0d", d), 32'(stale), 32'd0);
        check($sformatf("ready_d%0d", d), 32'(in_ready), 32'd1);
    endtask

    initial begin
        int accepts;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_dist   = '0;
        in_side   = 1'b0;
        row_start = 1'b0;
        step(2);
        check("rst_size", 32'(size), 32'd0);
        check("rst_side", 32'(side), 32'd0);
        check("rst_stale", 32'(stale), 32'd0);
        reset = 1'b0;
        step(1);
        check("rst_ready", 32'(in_ready), 32'd1);

        // Reset in the middle of a divide discards it.
        accept(16'd1024, 1'b1);
        step(5);
        reset = 1'b1;
        #2;
        check("midrst_size", 32'(size), 32'd0);
        reset = 1'b0;
        step(1);
        check("midrst_ready", 32'(in_ready), 32'd1);
        commit();
        check("midrst_stale", 32'(stale), 32'd1);
        check("midrst_size_hold", 32'(size), 32'd0);

        run_div(16'd1024, 1'b1, 11'd512);
        run_div(16'd257, 1'b0, 11'd2040);
        run_div(16'd2048, 1'b1, 11'd256);
        run_div(16'd65535, 1'b0, 11'd8);
        run_div(16'd256, 1'b1, 11'd2047);

        // Zero distance: pending after a single edge.
        accept(16'd0, 1'b0);
        step(1);
        commit();
        check("size_d0", 32'(size), 32'd2047);
        check("side_d0", 32'(side), 32'd0);
        check("stale_d0", 32'(stale), 32'd0);

        // row_start on the DONE edge misses the result.
        accept(16'd2048, 1'b1);
        step(20);
        commit();
        check("sim_stale", 32'(stale), 32'd1);
        check("sim_size_hold", 32'(size), 32'd2047);
        check("sim_side_hold", 32'(side), 32'd0);
        step(1);
        commit();
        check("sim_size_new", 32'(size), 32'd256);
        check("sim_side_new", 32'(side), 32'd1);
        check("sim_stale_clr", 32'(stale), 32'd0);

        // Second row_start with nothing new.
        commit();
        check("dbl_stale", 32'(stale), 32'd1);
        check("dbl_size_hold", 32'(size), 32'd256);
        check("dbl_side_hold", 32'(side), 32'd1);

        // in_valid held high: exactly one accept per commit.
        in_dist  = 16'd65535;
        in_side  = 1'b1;
        in_valid = 1'b1;
        accepts  = 0;
        for (int i = 0; i < 25; i++) begin
            if (in_ready) accepts++;
            step(1);
        end
        check("held_accepts", 32'(accepts), 32'd1);
        commit();
        check("held_size", 32'(size), 32'd8);
        check("held_side", 32'(side), 32'd1);
        check("held_ready_after_commit", 32'(in_ready), 32'd1);
        in_dist = 16'd257;
        in_side = 1'b0;
        step(1);
        check("held_reaccept", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        step(21);
        commit();
        check("held2_size", 32'(size), 32'd2040);
        check("held2_side", 32'(side), 32'd0);
        check("held2_stale", 32'(stale), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wall_size_div.md
Name: wall_size_div

Overview:
- Upstream neighbour of the per-row renderer. Converts each ray's perpendicular wall distance into the 11-bit half-height `size` the renderer compares against `hpos`.
- Uses a serial restoring division: size = floor(SCALE_NUM / dist), saturated.
- Buffers one result together with its `side` bit.
- Commits that result to stable output registers only on a row-start pulse, so renderer inputs never change mid-row.

Parameters:
- DIST_W, 16, width of unsigned distance input (Q6.10 fixed point).
- SIZE_W, 11, width of size output; saturation value is 2^SIZE_W-1 = 2047.
- NUM_W, 20, width of the dividend constant; also the number of division iterations.
- SCALE_NUM, 524288 (2^19), dividend constant. Distance 1.0 (1024) maps to size 512.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  tracer presents a new distance/side.
- in_ready  out  1  block accepts the input this cycle.
- in_dist  in  DIST_W  perpendicular distance, unsigned.
- in_side  in  1  wall side flag of the hit.
- row_start  in  1  one-cycle pulse at the start of each rendered row.
- size  out  SIZE_W  committed wall half-height, held for the whole row.
- side  out  1  committed side flag.
- stale  out  1  high if the last row_start found no fresh result.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high.
- Reset values:
  - size=0, side=0, stale=0.
  - FSM=IDLE, pending_valid=0, so in_ready=1 once reset deasserts.
  - Reset mid-division aborts the operation; the partial result is discarded.
- in_ready = (FSM==IDLE) && !pending_valid. It is a function of registers only.
- Accept occurs when in_valid && in_ready at a rising edge. That edge latches in_dist and in_side.
- FSM:
  - IDLE -> DIV on accept with in_dist!=0. Remainder cleared, quotient cleared, iteration count set to NUM_W.
  - IDLE -> DONE on accept with in_dist==0. Quotient forced to saturate.
  - DIV: each cycle performs one restoring step, MSB-first over the SCALE_NUM bits.
    - rem' = {rem, next dividend bit}.
    - If rem' >= dist: subtract dist and shift in quotient bit 1; otherwise shift in 0.
    - Remainder is DIST_W+1 bits wide.
    - After NUM_W steps -> DONE.
  - DONE: one cycle. pending_size = (quotient > 2^SIZE_W-1) ? all-ones : quotient[SIZE_W-1:0]; pending_side = latched side; pending_valid=1. Then -> IDLE.
- Latency: pending_valid rises after NUM_W+1 edges following the accept edge (21 for defaults). For dist==0 it rises after 1 edge.
- row_start (sampled at edge):
  - If pending_valid: size<=pending_size, side<=pending_side, pending_valid<=0, stale<=0.
  - Else: size and side hold, stale<=1.
- Simultaneous DONE and row_start on the same edge: row_start sees the old pending_valid (0), so it sets stale=1. The new result is committed at the next row_start.
- Simultaneous row_start clearing pending and in_valid on the same edge: in_ready was 0 that cycle, so no accept. Accept becomes possible on the following edge.
- in_valid while not ready: ignored. The tracer must hold its data until accepted.
- At most one result is buffered. A second distance is never accepted until the pending result is committed.

Decomposition:
- Shared package holds:
  - DIST_W, SIZE_W, NUM_W, SCALE_NUM.
  - SIZE_MAX = 2^SIZE_W-1.
  - FSM state enum {IDLE, DIV, DONE}.
  - H_VIEW=640 / HALF_SIZE=320 constants already used by the renderer.
- One sub-module is natural: serial_udiv (start/busy/done, dividend, divisor -> quotient, remainder, NUM_W iterations).
- wall_size_div keeps the handshake, saturation, pending buffer and row commit.

Test Plan:
- Reset, then idle: size=0, side=0, stale=0, in_ready=1. Assert reset mid-DIV: in_ready=1 next cycle, no pending, outputs 0.
- dist=1024, side=1 accepted, wait 21 cycles, pulse row_start -> size=512, side=1, stale=0. in_ready is 0 from accept until row_start, and 1 the cycle after.
- dist=257 -> 2040; dist=2048 -> 256; dist=65535 -> 8; dist=256 -> 2047 (saturated). Each is committed via row_start.
- dist=0 -> pending after 1 edge; row_start -> size=2047.
- row_start issued on the same edge as DONE -> stale=1 and size unchanged. Next row_start -> new size, stale=0.
- Two consecutive row_start pulses with no new input -> second sets stale=1 and size/side hold their previous values. in_valid held high while busy -> exactly one accept per commit.
